// File: rtl/char_gen_pkg.sv
// Shared state encoding and field widths for the lane-parallel candidate generator.
package char_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int CNT_W     = 64;
  localparam int OFFSET_W  = 6;
  localparam int MAXCH_W   = 4;
  localparam int CHARSET_W = 7;
  localparam int LEN_W     = 4;

endpackage

// File: rtl/radix_add.sv
// Adds a small constant (at most the radix) to an L-digit radix-N number; a carry
// out of the top digit grows the length by one with the new top digit at zero.
module radix_add
  import char_gen_pkg::*;
#(
  parameter int MAX_CHARS = 8,
  parameter int CHAR_W    = 7
) (
  input  logic [MAX_CHARS*CHAR_W-1:0] digits_i,
  input  logic [LEN_W-1:0]            len_i,
  input  logic [CHAR_W-1:0]           radix_i,
  input  logic [CHAR_W-1:0]           addend_i,
  output logic [MAX_CHARS*CHAR_W-1:0] digits_o,
  output logic [LEN_W-1:0]            len_o
);

  logic [CHAR_W:0] sum;
  logic [CHAR_W:0] carry;

  always_comb begin
    digits_o = '0;
    len_o    = len_i;
    sum      = '0;
    carry    = {1'b0, addend_i};
    for (int d = 0; d < MAX_CHARS; d++) begin
      if (d < int'(len_i)) begin
        sum = {1'b0, digits_i[d*CHAR_W +: CHAR_W]} + carry;
        // addend <= radix and digit < radix, so one subtraction always normalises
        if (sum >= {1'b0, radix_i}) begin
          digits_o[d*CHAR_W +: CHAR_W] = CHAR_W'(sum - {1'b0, radix_i});
          carry = (CHAR_W+1)'(1);
        end else begin
          digits_o[d*CHAR_W +: CHAR_W] = sum[CHAR_W-1:0];
          carry = '0;
        end
      end
    end
    if (carry != '0) begin
      len_o = len_i + LEN_W'(1);
    end
  end

endmodule

// File: rtl/lane_char_gen.sv
// Enumerates radix-N candidates of length 1..max_characters, LANES consecutive
// candidates per ready/valid beat, with a running count of real candidates.
module lane_char_gen
  import char_gen_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int MAX_CHARS = 8,
  parameter int CHAR_W    = 7
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [OFFSET_W-1:0]               start_offset,
  input  logic [MAXCH_W-1:0]                max_characters,
  input  logic [CHARSET_W-1:0]              charset_size,
  output logic                              word_valid,
  input  logic                              word_ready,
  output logic [LANES*MAX_CHARS*CHAR_W-1:0] digits_out,
  output logic [LANES*LEN_W-1:0]            length_out,
  output logic [LANES-1:0]                  lane_valid,
  output logic [OFFSET_W-1:0]               offset_out,
  output logic [CNT_W-1:0]                  word_counter,
  output logic                              finished,
  output logic                              config_err
);

  localparam int DW = MAX_CHARS * CHAR_W;

  state_e                state_q, state_d;
  logic [DW-1:0]         base_q, base_d;
  logic [LEN_W-1:0]      base_len_q, base_len_d;
  logic [MAXCH_W-1:0]    max_q, max_d;
  logic [CHARSET_W-1:0]  n_q, n_d;
  logic [OFFSET_W-1:0]   offset_q, offset_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  fin_q, fin_d;
  logic                  err_q, err_d;

  logic [DW-1:0]         lane_dig [LANES];
  logic [LEN_W-1:0]      lane_len [LANES];
  logic [LANES-1:0]      lane_ok;
  logic [DW-1:0]         next_dig;
  logic [LEN_W-1:0]      next_len;
  logic [CNT_W-1:0]      pop;
  logic                  run;
  logic                  cfg_bad;
  logic [CHAR_W-1:0]     radix;

  assign run   = (state_q == ST_RUN);
  assign radix = CHAR_W'(n_q);

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      radix_add #(.MAX_CHARS(MAX_CHARS), .CHAR_W(CHAR_W)) u_lane (
        .digits_i (base_q),
        .len_i    (base_len_q),
        .radix_i  (radix),
        .addend_i (CHAR_W'(gi)),
        .digits_o (lane_dig[gi]),
        .len_o    (lane_len[gi])
      );
      assign lane_ok[gi] = (lane_len[gi] <= max_q);
      // Lane outputs read as zero outside RUN so reset and idle look clean.
      assign digits_out[gi*DW +: DW]       = run ? lane_dig[gi] : '0;
      assign length_out[gi*LEN_W +: LEN_W] = run ? lane_len[gi] : '0;
      assign lane_valid[gi]                = run & lane_ok[gi];
    end
  endgenerate

  radix_add #(.MAX_CHARS(MAX_CHARS), .CHAR_W(CHAR_W)) u_base (
    .digits_i (base_q),
    .len_i    (base_len_q),
    .radix_i  (radix),
    .addend_i (CHAR_W'(LANES)),
    .digits_o (next_dig),
    .len_o    (next_len)
  );

  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) begin
      pop = pop + CNT_W'(lane_ok[i]);
    end
  end

  assign cfg_bad = (charset_size < CHARSET_W'(2)) || (int'(charset_size) < LANES) ||
                   (max_characters == '0) || (int'(max_characters) > MAX_CHARS);

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    base_len_d = base_len_q;
    max_d      = max_q;
    n_d        = n_q;
    offset_d   = offset_q;
    cnt_d      = cnt_q;
    fin_d      = fin_q;
    err_d      = err_q;
    if (run && word_ready) begin
      base_d     = next_dig;
      base_len_d = next_len;
      cnt_d      = cnt_q + pop;
      if (!(&lane_ok) || (next_len > max_q)) begin
        state_d = ST_DONE;
        fin_d   = 1'b1;
      end
    end
    // A start overrides any beat accepted in the same cycle.
    if (start) begin
      max_d      = max_characters;
      n_d        = charset_size;
      offset_d   = start_offset;
      cnt_d      = '0;
      base_d     = '0;
      base_len_d = LEN_W'(1);
      err_d      = cfg_bad;
      fin_d      = cfg_bad;
      state_d    = cfg_bad ? ST_DONE : ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      base_len_q <= '0;
      max_q      <= '0;
      n_q        <= '0;
      offset_q   <= '0;
      cnt_q      <= '0;
      fin_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      base_len_q <= base_len_d;
      max_q      <= max_d;
      n_q        <= n_d;
      offset_q   <= offset_d;
      cnt_q      <= cnt_d;
      fin_q      <= fin_d;
      err_q      <= err_d;
    end
  end

  assign word_valid   = run;
  assign offset_out   = offset_q;
  assign word_counter = cnt_q;
  assign finished     = fin_q;
  assign config_err   = err_q;

endmodule
